accum_rr_sched: RTL and testbench
=================================

Name: accum_rr_sched

Overview:
- Round-robin scheduler that shares one unsigned running-sum accumulator among NREQ requesters.
- Each granted requester streams a burst of len+1 samples over a shared valid/ready bus.
- The block sums the burst and reports the result, the requester ID and an overflow flag.
- Sits between the sample producers and downstream result consumers; it is the sole owner and sequencer of the accumulator.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 5, sample width, unsigned
- SW, 11, sum width, unsigned; sum wraps modulo 2^SW
- LENW, 7, burst-length field width; burst = len+1 samples (1..128)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester burst request, level
- len  in  NREQ*LENW  per-requester burst length minus one; slice i = len[i*LENW +: LENW]
- gnt  out  NREQ  one-hot grant; all zero when idle
- din  in  DW  shared sample bus, driven by the granted requester
- din_valid  in  1  sample present
- din_ready  out  1  accumulator accepting
- sum  out  SW  burst result, held until next sum_valid
- sum_id  out  $clog2(NREQ)  index of requester that produced sum
- sum_valid  out  1  one-cycle result strobe
- ovf  out  1  burst carried out of SW bits; valid with sum, held with sum

Behaviour:
- Reset (async assert, any state):
  - state=IDLE; gnt=0; din_ready=0; sum=0; sum_id=0; sum_valid=0; ovf=0; acc=0; cnt=0; ptr=0.
  - Reset mid-burst discards the burst with no sum_valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any req is high, pick the first high req searching from ptr upward, wrapping modulo NREQ.
  - Register on that edge: gnt one-hot winner, wid=winner, blen=len[winner], acc=0, cnt=0, ovf_int=0.
  - Next state RUN.
  - Grant is visible the cycle after req is sampled.
- RUN:
  - din_ready=1; gnt held.
  - A sample is accepted on din_valid&&din_ready: {carry,acc} = acc + zero-extended din; ovf_int |= carry; cnt++.
  - din_valid low gives a stall cycle with no change; gaps of any length are legal.
  - On accepting the sample with cnt==blen, next state is DONE.
  - req and len are ignored during RUN. Dropping req does not abort the burst; the requester must complete it.
- DONE (exactly one cycle):
  - gnt=0; din_ready=0; sum_valid=1.
  - sum = final acc, including the last sample; sum_id=wid; ovf=ovf_int.
  - ptr=(wid+1) mod NREQ.
  - Next state IDLE.
- Latency:
  - sum_valid is asserted the cycle after the last sample is accepted.
  - Minimum gap between the end of one burst and the next grant is 2 cycles (DONE, IDLE).
- Fairness: with every req held high, grants rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ-1 bursts.
- Width rules:
  - Samples are zero-extended to SW.
  - The carry out of SW bits sets the sticky ovf for that burst only.
  - ovf is cleared at the next grant, internally; the output ovf updates only at DONE.
- len=0 means a single-sample burst.
- Only one gnt bit is ever high. din is sampled only when din_valid&&din_ready.

Decomposition:
- Shared package accum_pkg holds:
  - state enum {IDLE,RUN,DONE}
  - default constants NREQ/DW/SW/LENW
  - IDW = $clog2(NREQ)
- Sub-module rr_arbiter (NREQ): inputs req and ptr, outputs one-hot grant and index. Purely combinational priority rotate.
- All state lives in accum_rr_sched.

Test Plan:
- Single burst:
  - Stimulus: req[0]=1, len0=2, samples 1,2,3 back-to-back.
  - Required: gnt=0001 one cycle after req; sum_valid one cycle after 3rd sample; sum=6, sum_id=0, ovf=0; gnt=0 in DONE.
- Valid gaps:
  - Stimulus: req[2], len2=3, samples 31,0,31,31 with 2 idle cycles between each.
  - Required: sum=93, sum_id=2, din_ready high throughout RUN.
- Round-robin:
  - Stimulus: req=1111 held, every len=0, sample=i+1 for requester i.
  - Required: sum_id sequence 0,1,2,3,0 with sums 1,2,3,4,1; never two gnt bits high.
  - Then raise only req[1] right after requester 1 finishes: next grant still goes to 1 (ptr=2, search wraps).
- Overflow:
  - Stimulus: req[3], len3=127, 128 samples of 31.
  - Required: sum=3968 mod 2048=1920, ovf=1.
  - Following burst of 5 gives sum=5, ovf=0.
- Abort on reset:
  - Stimulus: rst pulsed asynchronously (not clock-aligned) after 2 of 4 samples.
  - Required: all outputs 0 immediately, no sum_valid.
  - After release, req[1] gets grant first (ptr=0 and req[0] low); a 4-sample burst of 1s gives sum=4.
- Req drop mid-burst:
  - Stimulus: req[0] deasserted during RUN.
  - Required: gnt held; burst completes and reports normally.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and default sizing for the round-robin accumulator scheduler.
// IDW only matches the default NREQ; parameterised modules derive their own.
package accum_pkg;

  localparam int NREQ = 4;
  localparam int DW   = 5;
  localparam int SW   = 11;
  localparam int LENW = 7;
  localparam int IDW  = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/accum_rr_sched_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or above ptr_i wins,
// with the search wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = accum_pkg::NREQ,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/accum_rr_sched.sv
// Round-robin scheduler sharing one running-sum accumulator among NREQ requesters;
// each granted requester streams len+1 samples and gets back its wrapped sum plus a carry flag.
module accum_rr_sched #(
  parameter int NREQ = accum_pkg::NREQ,
  parameter int DW   = accum_pkg::DW,
  parameter int SW   = accum_pkg::SW,
  parameter int LENW = accum_pkg::LENW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*LENW-1:0]     len,
  output logic [NREQ-1:0]          gnt,
  input  logic [DW-1:0]            din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [SW-1:0]            sum,
  output logic [$clog2(NREQ)-1:0]  sum_id,
  output logic                     sum_valid,
  output logic                     ovf
);
  import accum_pkg::*;

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   wid_q, wid_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   sumId_q, sumId_d;
  logic [LENW-1:0] blen_q, blen_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic            ovfInt_q, ovfInt_d;
  logic            ovf_q, ovf_d;

  logic [NREQ-1:0] arbGnt;
  logic [IW-1:0]   arbIdx;
  logic            arbAny;
  logic [SW:0]     accSum;
  logic            accept;
  logic [LENW-1:0] lenArr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : gLenSplit
    assign lenArr[g] = len[g*LENW +: LENW];
  end

  rr_arbiter #(.NREQ(NREQ)) uArb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arbGnt),
    .idx_o (arbIdx),
    .any_o (arbAny)
  );

  // Extra top bit of accSum is the carry out of the SW-bit accumulator.
  assign accept = din_valid && (state_q == RUN);
  assign accSum = {1'b0, acc_q} + {{(SW + 1 - DW){1'b0}}, din};

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    wid_d    = wid_q;
    ptr_d    = ptr_q;
    sumId_d  = sumId_q;
    blen_d   = blen_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    ovfInt_d = ovfInt_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (arbAny) begin
          gnt_d    = arbGnt;
          wid_d    = arbIdx;
          blen_d   = lenArr[arbIdx];
          acc_d    = '0;
          cnt_d    = '0;
          ovfInt_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          acc_d    = accSum[SW-1:0];
          ovfInt_d = ovfInt_q | accSum[SW];
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == blen_q) begin
            state_d = DONE;
            gnt_d   = '0;
            sum_d   = accSum[SW-1:0];
            sumId_d = wid_q;
            ovf_d   = ovfInt_q | accSum[SW];
            ptr_d   = (wid_q == IW'(NREQ - 1)) ? '0 : wid_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      wid_q    <= '0;
      ptr_q    <= '0;
      sumId_q  <= '0;
      blen_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      ovfInt_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      wid_q    <= wid_d;
      ptr_q    <= ptr_d;
      sumId_q  <= sumId_d;
      blen_q   <= blen_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      ovfInt_q <= ovfInt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign gnt       = gnt_q;
  assign din_ready = (state_q == RUN);
  assign sum_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign sum_id    = sumId_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_accum_rr_sched.sv
// Directed bench for accum_rr_sched: a burst-level model predicts grant order and results,
// and a per-cycle monitor compares every result strobe and held output against it.
module tb_accum_rr_sched;

  localparam int NREQ = 4;
  localparam int DW   = 5;
  localparam int SW   = 11;
  localparam int LENW = 7;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*LENW-1:0]    lenBus;
  logic [NREQ-1:0]         gnt;
  logic [DW-1:0]           din;
  logic                    din_valid;
  logic                    din_ready;
  logic [SW-1:0]           sum;
  logic [$clog2(NREQ)-1:0] sum_id;
  logic                    sum_valid;
  logic                    ovf;

  int total = 0;
  int bad   = 0;
  int expId[$];
  int expSum[$];
  int expOvf[$];
  int burstQ[$];
  int heldSum, heldId, heldOvf;
  int modelPtr;
  logic [NREQ-1:0] curReq;
  int got, waited;
  int rrExp [7] = '{0, 1, 2, 3, 0, 1, 1};

  always #5 clk = ~clk;

  accum_rr_sched #(.NREQ(NREQ), .DW(DW), .SW(SW), .LENW(LENW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .len       (lenBus),
    .gnt       (gnt),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sum       (sum),
    .sum_id    (sum_id),
    .sum_valid (sum_valid),
    .ovf       (ovf)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pickWinner(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic setLen(input int i, input int v);
    lenBus[i*LENW +: LENW] = LENW'(v);
  endtask

  // Serve one grant: verify the winner, stream burstQ, record the expected result.
  task automatic applyStimulus(input int gap, input logic [NREQ-1:0] nextReq,
                               output int gotId, output int waitCycles);
    int want = pickWinner(curReq, modelPtr);
    int acc = 0;
    logic [NREQ-1:0] oh;
    waitCycles = 0;
    gotId = -1;
    while (gnt == '0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("grant_seen", gnt != '0, 1);
    if (gnt == '0) return;
    oh = NREQ'(1) << want;
    checkOutput("gnt_winner", gnt, oh);
    for (int b = 0; b < NREQ; b++) if (gnt[b]) gotId = b;
    req = nextReq;
    curReq = nextReq;
    for (int i = 0; i < burstQ.size(); i++) begin
      if (i > 0) begin
        repeat (gap) begin
          din_valid = 1'b0;
          @(negedge clk);
          checkOutput("ready_gap", din_ready, 1);
          checkOutput("gnt_held_gap", gnt, oh);
        end
      end
      checkOutput("gnt_held", gnt, oh);
      checkOutput("ready_run", din_ready, 1);
      din = DW'(burstQ[i]);
      din_valid = 1'b1;
      acc += burstQ[i];
      if (i == burstQ.size() - 1) begin
        expId.push_back(gotId);
        expSum.push_back(acc % (1 << SW));
        expOvf.push_back(acc >= (1 << SW));
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    checkOutput("sum_valid_latency", sum_valid, 1);
    modelPtr = (gotId + 1) % NREQ;
  endtask

  // Per-cycle monitor: result strobes against the model queue, held outputs otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("gnt_onehot", $countones(gnt) <= 1, 1);
      if (sum_valid) begin
        if (expId.size() == 0) begin
          checkOutput("unexpected_sum_valid", expId.size(), 1);
        end else begin
          heldId  = expId.pop_front();
          heldSum = expSum.pop_front();
          heldOvf = expOvf.pop_front();
          checkOutput("sum_id", sum_id, heldId);
          checkOutput("sum", sum, heldSum);
          checkOutput("ovf", ovf, heldOvf);
          checkOutput("gnt_in_done", gnt, 0);
          checkOutput("ready_in_done", din_ready, 0);
        end
      end else begin
        checkOutput("sum_hold", sum, heldSum);
        checkOutput("sum_id_hold", sum_id, heldId);
        checkOutput("ovf_hold", ovf, heldOvf);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got %0d, expected 0", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; req = '0; curReq = '0; lenBus = '0; din = '0; din_valid = 1'b0;
    modelPtr = 0; heldSum = 0; heldId = 0; heldOvf = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_ready", din_ready, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_sum_id", sum_id, 0);
    checkOutput("rst_sum_valid", sum_valid, 0);
    checkOutput("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single burst 1,2,3 from requester 0.
    setLen(0, 2);
    burstQ.delete(); burstQ.push_back(1); burstQ.push_back(2); burstQ.push_back(3);
    req = 4'b0001; curReq = req;
    applyStimulus(0, 4'b0000, got, waited);
    checkOutput("single_grant_delay", waited, 1);
    checkOutput("single_sum", sum, 6);
    checkOutput("single_id", sum_id, 0);
    checkOutput("single_ovf", ovf, 0);
    checkOutput("single_gnt_done", gnt, 0);

    // Requester 2 with two idle cycles between samples.
    setLen(2, 3);
    burstQ.delete(); burstQ.push_back(31); burstQ.push_back(0); burstQ.push_back(31); burstQ.push_back(31);
    req = 4'b0100; curReq = req;
    applyStimulus(2, 4'b0000, got, waited);
    checkOutput("gap_sum", sum, 93);
    checkOutput("gap_id", sum_id, 2);

    // 128 samples of 31 overflow the 11-bit sum; the next burst clears the flag.
    setLen(3, 127);
    burstQ.delete();
    for (int i = 0; i < 128; i++) burstQ.push_back(31);
    req = 4'b1000; curReq = req;
    applyStimulus(0, 4'b1000, got, waited);
    checkOutput("ovf_sum", sum, 1920);
    checkOutput("ovf_flag", ovf, 1);
    setLen(3, 0);
    burstQ.delete(); burstQ.push_back(5);
    applyStimulus(0, 4'b0000, got, waited);
    checkOutput("post_ovf_sum", sum, 5);
    checkOutput("post_ovf_flag", ovf, 0);

    // All requesting: rotation 0,1,2,3,0,1, then only req[1] wraps back to 1.
    for (int i = 0; i < NREQ; i++) setLen(i, 0);
    req = 4'b1111; curReq = req;
    for (int k = 0; k < 7; k++) begin
      burstQ.delete();
      burstQ.push_back(pickWinner(curReq, modelPtr) + 1);
      applyStimulus(0, (k < 5) ? 4'b1111 : ((k == 5) ? 4'b0010 : 4'b0000), got, waited);
      checkOutput("rr_order", got, rrExp[k]);
      checkOutput("rr_sum", sum, rrExp[k] + 1);
    end

    // Requester 0 drops req right after grant; burst must still complete.
    setLen(0, 3);
    burstQ.delete(); burstQ.push_back(7); burstQ.push_back(8); burstQ.push_back(9); burstQ.push_back(10);
    req = 4'b0001; curReq = req;
    applyStimulus(1, 4'b0000, got, waited);
    checkOutput("drop_sum", sum, 34);
    checkOutput("drop_id", sum_id, 0);

    // Asynchronous reset after two of four samples discards the burst.
    setLen(2, 3);
    setLen(1, 3);
    req = 4'b0100; curReq = req;
    waited = 0;
    while (gnt == '0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("abort_grant", gnt, 4'b0100);
    repeat (2) begin
      din = 5'd1; din_valid = 1'b1;
      @(negedge clk);
    end
    #3 rst = 1'b1;
    #1;
    checkOutput("abort_gnt", gnt, 0);
    checkOutput("abort_ready", din_ready, 0);
    checkOutput("abort_sum_valid", sum_valid, 0);
    checkOutput("abort_sum", sum, 0);
    checkOutput("abort_sum_id", sum_id, 0);
    checkOutput("abort_ovf", ovf, 0);
    din_valid = 1'b0;
    req = 4'b0010; curReq = req;
    modelPtr = 0; heldSum = 0; heldId = 0; heldOvf = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    burstQ.delete();
    for (int i = 0; i < 4; i++) burstQ.push_back(1);
    applyStimulus(0, 4'b0000, got, waited);
    checkOutput("after_abort_id", got, 1);
    checkOutput("after_abort_sum", sum, 4);

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", expId.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
